// File: rtl/program_loader_pkg.sv
// Shared types and frame-field constants for the byte-stream program loader.
package program_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_CSUM  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [7:0] START_BYTE_DEF = 8'hA5;
  localparam int BYTE_W = 8;
  localparam int NIB_W  = 4;
endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte watchdog: reloads on every strobe, expires after TIMEOUT_CYCLES idle clocks.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic strobe,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (strobe || !arm)   cnt <= RELOAD;
    else if (cnt != '0)        cnt <= cnt - 1'b1;
  end

  // Reaching zero means TIMEOUT_CYCLES-1 idle edges have passed; the next idle edge is the last.
  assign expire = arm && !strobe && (cnt == '0);
endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader writing 12-bit words into program RAM while holding the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter int         DATA_WIDTH     = 12,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] START_BYTE     = START_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);
  localparam int REM_W = ADDR_WIDTH + 1;

  state_t             state, state_nxt;
  logic [REM_W-1:0]   rem;
  logic [NIB_W-1:0]   nibble;
  logic [BYTE_W-1:0]  sum;
  logic               start, take_count, take_hi, take_lo, done_nxt;
  logic               in_frame, expire;

  assign in_frame = (state == ST_COUNT) || (state == ST_HI) ||
                    (state == ST_LO)    || (state == ST_CSUM);

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .arm    (in_frame),
    .strobe (rx_valid),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    take_count = 1'b0;
    take_hi    = 1'b0;
    take_lo    = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE, ST_ERR:
        if (rx_valid && rx_data == START_BYTE) begin
          state_nxt = ST_COUNT;
          start     = 1'b1;
        end
      ST_COUNT:
        if (rx_valid) begin
          state_nxt  = ST_HI;
          take_count = 1'b1;
        end
      ST_HI:
        if (rx_valid) begin
          if (rx_data[7:4] != 4'h0) state_nxt = ST_ERR;
          else begin
            state_nxt = ST_LO;
            take_hi   = 1'b1;
          end
        end
      ST_LO:
        if (rx_valid) begin
          take_lo   = 1'b1;
          state_nxt = (rem == REM_W'(1)) ? ST_CSUM : ST_HI;
        end
      ST_CSUM:
        if (rx_valid) begin
          if (rx_data == sum) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else state_nxt = ST_ERR;
        end
      default: state_nxt = ST_IDLE;
    endcase
    if (expire) state_nxt = ST_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      load_done <= 1'b0;
      rem       <= '0;
      nibble    <= '0;
      sum       <= '0;
    end else begin
      ram_we    <= take_lo;
      load_done <= done_nxt;
      // Address advances the cycle after each write pulse and wraps after the last word.
      if (start)       ram_addr <= '0;
      else if (ram_we) ram_addr <= ram_addr + 1'b1;
      if (start)                              sum <= '0;
      else if (take_count || take_hi || take_lo) sum <= sum + rx_data;
      if (take_count)
        rem <= (rx_data == 8'h00) ? REM_W'(1 << ADDR_WIDTH) : REM_W'(rx_data);
      else if (take_lo)
        rem <= rem - 1'b1;
      if (take_hi) nibble <= rx_data[NIB_W-1:0];
      if (take_lo) ram_din <= DATA_WIDTH'({nibble, rx_data});
    end
  end

  assign cpu_hold = (state != ST_IDLE);
  assign load_err = (state == ST_ERR);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good frames, 256-word frame, checksum/HI errors, timeout, reset.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  ram_addr;
  logic [11:0] ram_din;
  logic        ram_we, cpu_hold, load_done, load_err;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [7:0]  txq[$];
  logic [19:0] wlog[$];

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_WIDTH(8), .DATA_WIDTH(12), .TIMEOUT_CYCLES(16), .START_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always @(negedge clk) begin
    if (ram_we) wlog.push_back({ram_addr, ram_din});
    if (load_done) done_cnt++;
  end

  // Streams txq back-to-back; returns at the negedge right after the last byte's edge.
  task send_q();
    for (int i = 0; i < txq.size(); i++) begin
      @(negedge clk);
      rx_data  = txq[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    txq.delete();
  endtask

  task test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_din, ram_we, cpu_hold, load_done, load_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h din=%h we=%b hold=%b done=%b err=%b expected all 0",
               ram_addr, ram_din, ram_we, cpu_hold, load_done, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_good_frame();
    logic [19:0] exp_w[3];
    int d0;
    exp_w[0] = 20'h00991; exp_w[1] = 20'h01E07; exp_w[2] = 20'h026D1;
    wlog.delete();
    d0 = done_cnt;
    txq = '{8'hA5, 8'h03, 8'h09, 8'h91};
    send_q();
    checks++;
    if (cpu_hold !== 1'b1) begin
      errors++; $display("FAIL good_hold_mid: got %b expected 1", cpu_hold);
    end
    txq = '{8'h0E, 8'h07, 8'h06, 8'hD1, 8'h89};
    send_q();
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL good_end: got done/hold/err=%b%b%b expected 100", load_done, cpu_hold, load_err);
    end
    checks++;
    if (wlog.size() != 3) begin
      errors++; $display("FAIL good_wcount: got %0d expected 3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog[i] !== exp_w[i]) begin
          errors++; $display("FAIL good_write%0d: got %h expected %h", i, wlog[i], exp_w[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || done_cnt != d0 + 1) begin
      errors++; $display("FAIL good_done_pulse: got done=%b pulses=%0d expected 0 and 1", load_done, done_cnt - d0);
    end
  endtask

  task test_back_to_back();
    logic [7:0]  hi, lo, sum;
    logic [19:0] exp;
    int bad, d0;
    wlog.delete();
    d0 = done_cnt;
    sum = 8'h00;
    txq = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) begin
      hi = {4'h0, 4'(i)};
      lo = 8'(i) ^ 8'h5A;
      sum = sum + hi + lo;
      txq.push_back(hi);
      txq.push_back(lo);
    end
    txq.push_back(sum);
    send_q();
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_end: got done/hold/err=%b%b%b expected 100", load_done, cpu_hold, load_err);
    end
    checks++;
    if (wlog.size() != 256) begin
      errors++; $display("FAIL b2b_wcount: got %0d expected 256", wlog.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        exp = {8'(i), 4'(i), 8'(i) ^ 8'h5A};
        if (wlog[i] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL b2b_writes: got %0d bad writes expected 0", bad);
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task test_bad_csum();
    int d0;
    wlog.delete();
    d0 = done_cnt;
    txq = '{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'h00};
    send_q();
    repeat (2) @(negedge clk);
    checks++;
    if (wlog.size() != 1 || wlog[0] !== 20'h00FFF) begin
      errors++; $display("FAIL csum_write: got n=%0d first=%h expected 1 write 00fff",
                         wlog.size(), (wlog.size() > 0) ? wlog[0] : 20'h0);
    end
    checks++;
    if ({load_err, cpu_hold} !== 2'b11 || done_cnt != d0) begin
      errors++; $display("FAIL csum_err: got err=%b hold=%b dones=%0d expected 1 1 0",
                         load_err, cpu_hold, done_cnt - d0);
    end
  endtask

  task test_hi_err();
    int d0;
    txq = '{8'hA5};
    send_q();
    checks++;
    if ({load_err, cpu_hold} !== 2'b01) begin
      errors++; $display("FAIL restart_clears_err: got err=%b hold=%b expected 0 1", load_err, cpu_hold);
    end
    wlog.delete();
    txq = '{8'h02, 8'h1B, 8'h00};
    send_q();
    checks++;
    if ({load_err, cpu_hold} !== 2'b11 || wlog.size() != 0) begin
      errors++; $display("FAIL hi_err: got err=%b hold=%b writes=%0d expected 1 1 0",
                         load_err, cpu_hold, wlog.size());
    end
    d0 = done_cnt;
    txq = '{8'hA5, 8'h01, 8'h03, 8'h44, 8'h48};
    send_q();
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100 || wlog.size() != 1 || wlog[0] !== 20'h00344) begin
      errors++; $display("FAIL hi_recover: got done/hold/err=%b%b%b writes=%0d expected 100 with 00344",
                         load_done, cpu_hold, load_err, wlog.size());
    end
    @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL hi_recover_done: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task test_timeout();
    wlog.delete();
    txq = '{8'hA5, 8'h02, 8'h0A};
    send_q();
    repeat (15) @(negedge clk);
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early: got %b expected 0 at 15 idle clocks", load_err);
    end
    @(negedge clk);
    checks++;
    if ({load_err, cpu_hold} !== 2'b11 || wlog.size() != 0) begin
      errors++; $display("FAIL timeout_fire: got err=%b hold=%b writes=%0d expected 1 1 0",
                         load_err, cpu_hold, wlog.size());
    end
  endtask

  task test_reset_mid_frame();
    int d0;
    txq = '{8'hA5, 8'h03, 8'h01, 8'h11, 8'h02, 8'h22};
    send_q();
    checks++;
    if ({cpu_hold, load_err} !== 2'b10) begin
      errors++; $display("FAIL mid_hold: got hold=%b err=%b expected 1 0", cpu_hold, load_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_din, ram_we, cpu_hold, load_done, load_err} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got addr=%h din=%h we=%b hold=%b done=%b err=%b expected all 0",
               ram_addr, ram_din, ram_we, cpu_hold, load_done, load_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    d0 = done_cnt;
    txq = '{8'hA5, 8'h01, 8'h05, 8'h67, 8'h6D};
    send_q();
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100 || wlog.size() != 1 || wlog[0] !== 20'h00567) begin
      errors++; $display("FAIL post_reset_load: got done/hold/err=%b%b%b writes=%0d expected 100 with 00567",
                         load_done, cpu_hold, load_err, wlog.size());
    end
    @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++; $display("FAIL post_reset_done: got %0d expected 1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_bad_csum();
    test_hi_err();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
